valu_out_fifo: RTL
==================

# valu_out_fifo

Result queue directly downstream of the vector ALU. It captures each valid ALU result together with its destination vector-register-file address, buffers it in a first-word-fall-through FIFO, and drains entries to the VRF write port under a valid/ready handshake. The ALU has no backpressure, so this block absorbs write-port stalls and reports any results lost to overflow.

## Interface
- `DEPTH`, 8: number of entries; power of two, ≥2.
- `DW`, 32: result width.
- `AW`, 8: VRF address width.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: ALU result valid (ALU `valid_out`).
- `in_data` in DW: ALU result (ALU `out_res`).
- `in_addr` in AW: destination address (ALU `vrfo_addr`).
- `flush` in 1: synchronous queue clear.
- `vrf_we` out 1: head entry valid.
- `vrf_wdata` out DW: head entry data.
- `vrf_waddr` out AW: head entry address.
- `vrf_ready` in 1: VRF accepts the head entry this cycle.
- `count` out $clog2(DEPTH)+1: occupancy, 0..DEPTH.
- `full` out 1: `count == DEPTH`.
- `empty` out 1: `count == 0`.
- `overflow` out 1: sticky; set when a result is dropped.
- `drop_cnt` out 16: dropped-result counter. Present only with `VALU_OFQ_DROPCNT_EN`.

## Operation
- push_req = `in_valid` && `in_data != 32'hDEAD_DEAD`. A sentinel result is never stored, even when `in_valid` is asserted.
- pop = `vrf_we && vrf_ready`.
- Push is accepted when push_req && (!full || pop). A push is accepted when full only if a pop occurs in the same cycle.
- drop = push_req && full && !pop. On a drop, the entry is discarded, `overflow` is set to 1, and `drop_cnt` increments.
- Storage: circular buffer with write and read pointers of $clog2(DEPTH) bits. Pointers wrap modulo DEPTH. Full and empty are determined from `count`, not from pointer equality.
- `count` update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Simultaneous push and pop when empty is not possible, because `vrf_we` = 0 when empty. In that cycle the push is stored and no pop occurs.
- Output is first-word-fall-through: `vrf_we` = !empty, and `vrf_wdata`/`vrf_waddr` = mem[rd_ptr], taken combinationally from registered state.
- While `vrf_we` = 1 and `vrf_ready` = 0, the head outputs hold stable.
- `flush`:
  - Next edge: pointers = 0, count = 0.
  - Any push in the flush cycle is discarded and is not counted as a drop.
  - `overflow` and `drop_cnt` are kept.
- `rst`: pointers = 0, count = 0, overflow = 0, drop_cnt = 0. `rst` has priority over `flush`, push, and pop.
- Memory contents are not reset.

## Timing
- Reset values: `vrf_we` = 0, `count` = 0, `empty` = 1, `full` = 0, `overflow` = 0, `drop_cnt` = 0. `vrf_wdata`/`vrf_waddr` are don't-care while `vrf_we` = 0.
- Latency: a push accepted at edge N appears on `vrf_*` in the cycle after edge N when the queue was empty, i.e. 1 cycle in-to-out.
- Throughput: one push and one pop per cycle sustained.
- A pop at edge N shows the next entry, or `vrf_we` = 0, in the cycle after edge N.
- `count`, `full`, `empty`, and `overflow` reflect state after the last edge. There is no combinational path from `in_*` to any output.

## Configuration
- `VALU_OFQ_DROPCNT_EN` defined:
  - `drop_cnt` port and a 16-bit counter exist.
  - The counter increments on each drop and saturates at 16'hFFFF.
  - Cleared only by `rst`.
- Undefined: the `drop_cnt` port and the counter are absent. `overflow` remains.

## Structure
- Shared package `valu_pkg` holds:
  - `VALU_SENTINEL` = 32'hDEAD_DEAD, also used by the ALU.
  - typedef `valu_res_t` = packed struct {addr[AW-1:0], data[DW-1:0]} for the entry.
- Sub-module `valu_ofq_mem`: DEPTH × `valu_res_t` array with registered write and asynchronous read. Control logic (pointers, count, flags) stays in `valu_out_fifo`.

## Test plan
- Reset hold:
  - Stimulus: `rst` = 1 for 2 cycles with `in_valid` = 1.
  - Response: `count` = 0, `vrf_we` = 0, `overflow` = 0.
- Passthrough:
  - Stimulus: push data 0x0000_0005, addr 0x10, with `vrf_ready` = 1.
  - Response: next cycle `vrf_we` = 1, `vrf_wdata` = 5, `vrf_waddr` = 0x10. One cycle later `empty` = 1.
- Sentinel filter:
  - Stimulus: `in_valid` = 1 with `in_data` = 0xDEAD_DEAD.
  - Response: `count` stays 0 and no drop is recorded.
- Fill, overflow and order (DEPTH = 8, `vrf_ready` = 0):
  - Stimulus: push 1..9.
  - Response: `full` = 1 after 8 pushes. The 9th push sets `overflow` = 1, and `drop_cnt` = 1 when the macro is enabled.
  - Then raise `vrf_ready`: drains 1..8 in order with addresses intact.
- Full with simultaneous push and pop:
  - Stimulus: queue full, `vrf_ready` = 1, push 0xAA.
  - Response: `count` stays 8, no drop, and 0xAA is the last entry out.
- Stall, wrap and flush:
  - Stimulus: 20 random push/pop cycles with `vrf_ready` toggling.
  - Response: output matches a scoreboard model and head outputs stay stable while stalled.
  - Then `flush`: next cycle `count` = 0, and `overflow` is unchanged.

Source files
------------

// File: rtl/valu_pkg.sv
// Shared vector-ALU definitions: result sentinel and the result-queue entry.
package valu_pkg;

    localparam int VALU_DW = 32;
    localparam int VALU_AW = 8;

    // ALU emits this value when the result must not be written back.
    localparam logic [VALU_DW-1:0] VALU_SENTINEL = 32'hDEAD_DEAD;

    // One queued result: destination VRF address plus data.
    typedef struct packed {
        logic [VALU_AW-1:0] addr;
        logic [VALU_DW-1:0] data;
    } valu_res_t;

endpackage

// File: rtl/valu_ofq_mem.sv
// Storage array for the ALU result queue: registered write, asynchronous read.
module valu_ofq_mem
    import valu_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic            i_clk,
    input  logic            i_we,
    input  logic [PW-1:0]   i_waddr,
    input  valu_res_t       i_wdata,
    input  logic [PW-1:0]   i_raddr,
    output valu_res_t       o_rdata
);

    valu_res_t r_mem [DEPTH];

    // Write port; contents are intentionally not reset.
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/valu_out_fifo.sv
// ALU result queue: first-word-fall-through FIFO feeding the VRF write port.
// The ALU cannot be stalled, so results arriving while full are dropped and
// flagged on o_overflow. Optional drop counter: define VALU_OFQ_DROPCNT_EN.
// DW/AW must match the entry widths held in valu_pkg.
module valu_out_fifo
    import valu_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int DW    = VALU_DW,
    parameter int AW    = VALU_AW
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_in_valid,
    input  logic [DW-1:0]            i_in_data,
    input  logic [AW-1:0]            i_in_addr,
    input  logic                     i_flush,
    output logic                     o_vrf_we,
    output logic [DW-1:0]            o_vrf_wdata,
    output logic [AW-1:0]            o_vrf_waddr,
    input  logic                     i_vrf_ready,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_overflow
`ifdef VALU_OFQ_DROPCNT_EN
    ,output logic [15:0]             o_drop_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    logic          w_push_req;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    valu_res_t     w_wr_ent;
    valu_res_t     w_rd_ent;

    // Sentinel results are filtered before they can occupy a slot.
    assign w_push_req = i_in_valid && (i_in_data != VALU_SENTINEL);
    assign w_pop      = o_vrf_we && i_vrf_ready;
    // A push into a full queue only fits if the head leaves in the same cycle;
    // pushes during flush are discarded and not treated as drops.
    assign w_push     = w_push_req && (!o_full || w_pop) && !i_flush;
    assign w_drop     = w_push_req && o_full && !w_pop && !i_flush;

    assign w_wr_ent.addr = i_in_addr;
    assign w_wr_ent.data = i_in_data;

    valu_ofq_mem #(.DEPTH(DEPTH), .PW(PW)) u_mem (
        .i_clk   (i_clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wr_ent),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_ent)
    );

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (w_pop && !w_push) r_count <= r_count - CW'(1);
        end
    end

    // Sticky overflow flag; survives flush, cleared only by reset.
    always_ff @(posedge i_clk) begin
        if (i_rst)       r_overflow <= 1'b0;
        else if (w_drop) r_overflow <= 1'b1;
    end

`ifdef VALU_OFQ_DROPCNT_EN
    logic [15:0] r_drop_cnt;

    // Saturating count of dropped results.
    always_ff @(posedge i_clk) begin
        if (i_rst)                               r_drop_cnt <= '0;
        else if (w_drop && (r_drop_cnt != '1))   r_drop_cnt <= r_drop_cnt + 16'd1;
    end

    assign o_drop_cnt = r_drop_cnt;
`endif

    assign o_count     = r_count;
    assign o_full      = (r_count == CW'(DEPTH));
    assign o_empty     = (r_count == '0);
    assign o_overflow  = r_overflow;
    assign o_vrf_we    = !o_empty;
    assign o_vrf_wdata = w_rd_ent.data;
    assign o_vrf_waddr = w_rd_ent.addr;

endmodule
